zero_count_seq: RTL and testbench

Parametrised, multi-cycle successor to the 8-bit combinational zero counter. It accepts a WIDTH-bit word on a start strobe and scans it CHUNK bits per clock. It reports one of four counts: zeros, ones, leading zeros or trailing zeros. The result comes back with a one-cycle done pulse after a fixed latency. The block sits on the datapath wherever wide bit-statistics are needed without a WIDTH-deep adder tree in one cycle.

---
 rtl/zero_count_pkg.sv | 22 ++
 rtl/chunk_bit_count.sv | 34 +++
 rtl/zero_count_seq.sv | 106 ++++++++++
 tb/tb_zero_count_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/zero_count_pkg.sv
// Shared encodings and sizing helper for the sequential zero/one/leading/trailing counter.
package zero_count_pkg;

    typedef enum logic [1:0] {
        MODE_ZEROS = 2'b00,
        MODE_ONES  = 2'b01,
        MODE_LZ    = 2'b10,
        MODE_TZ    = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Bits needed to hold any count in 0..max_value inclusive.
    function automatic int count_width(input int max_value);
        return $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/chunk_bit_count.sv
// Combinational statistics for one CHUNK-bit slice: zero count, edge zero-run, any-one flag.
module chunk_bit_count
    import zero_count_pkg::*;
#(
    parameter int CHUNK = 8,
    localparam int CW = count_width(CHUNK)
) (
    input  logic [CHUNK-1:0] i_chunk,
    input  logic             i_from_msb,
    output logic [CW-1:0]    o_zeros,
    output logic [CW-1:0]    o_run,
    output logic             o_any_one
);

    logic w_seen;
    logic w_bit;

    // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        o_zeros = '0;
        o_run   = '0;
        w_seen  = 1'b0;
        w_bit   = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            if (!i_chunk[i]) o_zeros = o_zeros + CW'(1);
            w_bit  = i_from_msb ? i_chunk[CHUNK-1-i] : i_chunk[i];
            w_seen = w_seen | w_bit;
            if (!w_seen) o_run = o_run + CW'(1);
        end
    end

    assign o_any_one = |i_chunk;

endmodule

// File: rtl/zero_count_seq.sv
// Multi-cycle bit-statistics engine: scans a captured WIDTH-bit word CHUNK bits per clock.
module zero_count_seq
    import zero_count_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int CNT_W = count_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CW     = count_width(CHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    state_e           r_state, w_state_next;
    logic [WIDTH-1:0] r_data;
    mode_e            r_mode;
    logic [IDX_W-1:0] r_idx, w_sel_idx;
    logic [CNT_W-1:0] r_acc, r_count, w_add, w_acc_next;
    logic             r_hit, w_accept, w_last, w_from_msb;
    logic [CHUNK-1:0] w_chunks [NCHUNK];
    logic [CHUNK-1:0] w_chunk;
    logic [CW-1:0]    w_zeros, w_run;
    logic             w_any_one;

    for (genvar g = 0; g < NCHUNK; g++) begin : g_slice
        assign w_chunks[g] = r_data[g*CHUNK +: CHUNK];
    end

    // Leading-zero scans walk chunks from the MSB end; every other mode walks from the LSB end.
    assign w_from_msb = (r_mode == MODE_LZ);
    assign w_sel_idx  = w_from_msb ? (LAST_IDX - r_idx) : r_idx;
    assign w_chunk    = w_chunks[w_sel_idx];
    assign w_last     = (r_idx == LAST_IDX);
    assign w_accept   = start && (r_state != RUN);

    chunk_bit_count #(.CHUNK(CHUNK)) u_chunk (
        .i_chunk    (w_chunk),
        .i_from_msb (w_from_msb),
        .o_zeros    (w_zeros),
        .o_run      (w_run),
        .o_any_one  (w_any_one)
    );

    always_comb begin
        w_add = '0;
        case (r_mode)
            MODE_ZEROS: w_add = CNT_W'(w_zeros);
            MODE_ONES:  w_add = CNT_W'(CHUNK) - CNT_W'(w_zeros);
            default:    w_add = r_hit ? '0 : CNT_W'(w_run);
        endcase
    end

    assign w_acc_next = r_acc + w_add;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: w_state_next = start ? RUN : IDLE;
            RUN:        if (w_last) w_state_next = DONE;
            default:    w_state_next = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_mode  <= MODE_ZEROS;
            r_idx   <= '0;
            r_acc   <= '0;
            r_hit   <= 1'b0;
            r_count <= '0;
        end else if (w_accept) begin
            r_data <= data;
            r_mode <= mode_e'(mode);
            r_idx  <= '0;
            r_acc  <= '0;
            r_hit  <= 1'b0;
        end else if (r_state == RUN) begin
            r_idx <= r_idx + IDX_W'(1);
            r_acc <= w_acc_next;
            r_hit <= r_hit | w_any_one;
            if (w_last) r_count <= w_acc_next;
        end
    end

    assign busy  = (r_state == RUN);
    assign done  = (r_state == DONE);
    assign count = r_count;

endmodule

// File: tb/tb_zero_count_seq.sv
// Checks a 32/8 and a 64/16 instance against a per-cycle behavioural model plus literal results.
module tb_zero_count_seq;
    import zero_count_pkg::*;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start1;
    logic [31:0] data0;
    logic [63:0] data1;
    logic [1:0]  mode0, mode1;
    logic        busy0, busy1, done0, done1;
    logic [5:0]  count0;
    logic [6:0]  count1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    zero_count_seq #(.WIDTH(32), .CHUNK(8)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .data(data0), .mode(mode0),
        .busy(busy0), .done(done0), .count(count0)
    );

    zero_count_seq #(.WIDTH(64), .CHUNK(16)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .data(data1), .mode(mode1),
        .busy(busy1), .done(done1), .count(count1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Result of one scan straight from the definition of each mode.
    function automatic int ref_count(input logic [63:0] d, input int w, input logic [1:0] m);
        int ones = 0;
        int low  = w;
        int high = -1;
        for (int i = 0; i < w; i++) begin
            if (d[i]) begin
                ones++;
                if (low == w) low = i;
                high = i;
            end
        end
        case (m)
            2'b00:   return w - ones;
            2'b01:   return ones;
            2'b10:   return (high < 0) ? w : (w - 1 - high);
            default: return low;
        endcase
    endfunction

    // Model: a scan accepted when not busy finishes N edges later with done for one cycle.
    int m_left[2];
    bit m_done[2];
    int m_count[2];
    int m_pending[2];
    bit model_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            model_valid = 1'b1;
            for (int i = 0; i < 2; i++) begin
                m_left[i] = 0; m_done[i] = 1'b0; m_count[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit          s;
                logic [63:0] d;
                logic [1:0]  m;
                s = (i == 0) ? start0 : start1;
                d = (i == 0) ? {32'b0, data0} : data1;
                m = (i == 0) ? mode0 : mode1;
                m_done[i] = 1'b0;
                if (m_left[i] > 0) begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        m_done[i]  = 1'b1;
                        m_count[i] = m_pending[i];
                    end
                end else if (s) begin
                    m_left[i]    = N;
                    m_pending[i] = ref_count(d, (i == 0) ? 32 : 64, m);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("busy0",  64'(busy0),  64'(m_left[0] != 0));
            check("done0",  64'(done0),  64'(m_done[0]));
            check("count0", 64'(count0), 64'(m_count[0]));
            check("busy1",  64'(busy1),  64'(m_left[1] != 0));
            check("done1",  64'(done1),  64'(m_done[1]));
            check("count1", 64'(count1), 64'(m_count[1]));
        end
    end

    task automatic drive(input int inst, input bit s, input logic [63:0] d, input logic [1:0] m);
        if (inst == 0) begin
            start0 = s; data0 = d[31:0]; mode0 = m;
        end else begin
            start1 = s; data1 = d; mode1 = m;
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // One isolated scan with scrambled inputs after capture and a literal expected result.
    task automatic run_scan(input int inst, input logic [63:0] d, input logic [1:0] m, input int exp);
        string tag;
        tag = $sformatf("scan%0d_m%0d_%0h", inst, m, d);
        drive(inst, 1'b1, d, m);
        @(negedge clk);
        drive(inst, 1'b0, rand64(), 2'($urandom));
        repeat (N) @(negedge clk);
        check({tag, "_done"},  64'((inst == 0) ? done0 : done1), 64'd1);
        check({tag, "_count"}, (inst == 0) ? 64'(count0) : 64'(count1), 64'(exp));
        @(negedge clk);
        check({tag, "_done_off"}, 64'((inst == 0) ? done0 : done1), 64'd0);
    endtask

    initial begin
        int nd, nb;
        rst = 1'b1;
        drive(0, 1'b0, '0, 2'b00);
        drive(1, 1'b0, '0, 2'b00);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_count0", 64'(count0), 64'd0);
        check("reset_busy0",  64'(busy0),  64'd0);
        check("reset_done0",  64'(done0),  64'd0);

        run_scan(0, 64'h0000_0000, MODE_ZEROS, 32);
        run_scan(0, 64'h0000_0001, MODE_ZEROS, 31);
        run_scan(0, 64'h0000_000F, MODE_ZEROS, 28);
        run_scan(0, 64'h00FF_FFFF, MODE_ZEROS, 8);
        run_scan(0, 64'hFFFF_FFFF, MODE_ZEROS, 0);
        run_scan(0, 64'h0000_FFFF, MODE_ONES,  16);
        run_scan(0, 64'h0001_0000, MODE_LZ,    15);
        run_scan(0, 64'h0001_0000, MODE_TZ,    16);
        run_scan(0, 64'h0000_0000, MODE_LZ,    32);
        run_scan(0, 64'h0000_0000, MODE_TZ,    32);
        run_scan(0, 64'h8000_0000, MODE_LZ,    0);

        // Restart attempts in cycles 1 and 2 of a scan must be ignored.
        drive(0, 1'b1, 64'h0000_FFFF, MODE_ONES);
        @(negedge clk);
        drive(0, 1'b1, 64'hFFFF_FFFF, MODE_ZEROS);
        @(negedge clk);
        drive(0, 1'b1, 64'h1234_5678, MODE_LZ);
        @(negedge clk);
        drive(0, 1'b0, 64'h0, MODE_TZ);
        repeat (N - 2) @(negedge clk);
        check("ignore_done",  64'(done0),  64'd1);
        check("ignore_count", 64'(count0), 64'd16);
        @(negedge clk);
        check("ignore_no_restart", 64'(busy0), 64'd0);

        // Start held high: back-to-back scans, done and busy-low every fifth cycle.
        nd = 0; nb = 0;
        for (int i = 0; i < 15; i++) begin
            drive(0, 1'b1, rand64(), 2'($urandom));
            @(negedge clk);
            if (done0) nd++;
            if (!busy0) nb++;
        end
        drive(0, 1'b0, '0, 2'b00);
        check("held_done_pulses", 64'(nd), 64'd3);
        check("held_busy_low",    64'(nb), 64'd3);
        repeat (N + 2) @(negedge clk);

        // Reset in cycle 2 of a scan aborts it and clears count.
        run_scan(0, 64'h0000_0001, MODE_ZEROS, 31);
        drive(0, 1'b1, 64'h0, MODE_ZEROS);
        @(negedge clk);
        drive(0, 1'b0, 64'h0, MODE_ZEROS);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy",  64'(busy0),  64'd0);
        check("abort_done",  64'(done0),  64'd0);
        check("abort_count", 64'(count0), 64'd0);
        repeat (N + 1) @(negedge clk);

        run_scan(1, 64'h0000_0000_0000_0000, MODE_ZEROS, 64);
        run_scan(1, 64'h0000_0000_0000_0001, MODE_ZEROS, 63);
        run_scan(1, 64'h0000_0000_0000_000F, MODE_ZEROS, 60);
        run_scan(1, 64'h0000_0000_00FF_FFFF, MODE_ZEROS, 40);
        run_scan(1, 64'hFFFF_FFFF_FFFF_FFFF, MODE_ZEROS, 0);
        run_scan(1, 64'h0000_0000_0000_0000, MODE_LZ,    64);
        run_scan(1, 64'h0001_0000_0000_0000, MODE_TZ,    48);

        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 2; i++) begin
                logic [63:0] d;
                d = ($urandom_range(0, 7) == 0) ? 64'h0 : (rand64() >> $urandom_range(0, 63));
                drive(i, ($urandom_range(0, 2) == 0), d, 2'($urandom));
            end
            @(negedge clk);
        end
        drive(0, 1'b0, '0, 2'b00);
        drive(1, 1'b0, '0, 2'b00);
        repeat (N + 3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
